// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception controller feeding CP0.
// Synchronises external interrupts, forwards WB-stage mtc0 writes to
// Status/Cause/EPC, prioritises exception sources into a CP0 exception
// code, and issues flush/redirect followed by a fixed quiet window.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned QUIET_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [5:0]  int_raw_i,
    output logic [5:0]  int_o,

    input  logic        syscall_i,
    input  logic        inst_invalid_i,
    input  logic        trap_i,
    input  logic        ov_i,
    input  logic        eret_i,
    input  logic [31:0] inst_addr_i,
    input  logic        is_in_delayslot_i,

    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,

    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,

    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        quiet_o
);

    localparam int unsigned QCNT_W = 4;
    localparam logic [QCNT_W-1:0] QCNT_LOAD = QCNT_W'(QUIET_CYCLES - 32'd1);

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_QUIET = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [QCNT_W-1:0]  qcnt_q, qcnt_d;
    logic [5:0]         int_s1_q;
    logic [5:0]         int_s2_q;

    logic [31:0]        status_f;
    logic [31:0]        cause_f;
    logic [31:0]        epc_f;
    logic               int_pending;
    logic               slot_valid;
    logic [31:0]        code_c;
    logic               flush_c;
    logic [31:0]        new_pc_c;

    // Two-flop synchroniser for the asynchronous interrupt levels
    always_ff @(posedge clk) begin
        if (rst) begin
            int_s1_q <= 6'h00;
            int_s2_q <= 6'h00;
        end else begin
            int_s1_q <= int_raw_i;
            int_s2_q <= int_s1_q;
        end
    end

    assign int_o = int_s2_q;

    // Forward in-flight WB mtc0 writes; Cause only exposes its writable bits
    always_comb begin
        status_f = cp0_status_i;
        cause_f  = cp0_cause_i;
        epc_f    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            if (wb_cp0_waddr_i == CP0_STATUS) begin
                status_f = wb_cp0_data_i;
            end
            if (wb_cp0_waddr_i == CP0_CAUSE) begin
                cause_f[9:8]   = wb_cp0_data_i[9:8];
                cause_f[23:22] = wb_cp0_data_i[23:22];
            end
            if (wb_cp0_waddr_i == CP0_EPC) begin
                epc_f = wb_cp0_data_i;
            end
        end
    end

    assign int_pending = ((cause_f[15:8] & status_f[15:8]) != 8'h00)
                       && !status_f[1] && status_f[0];

    assign slot_valid = (inst_addr_i != 32'h0) && (state_q == S_IDLE) && !rst;

    // Fixed-priority exception encoding and redirect target
    always_comb begin
        code_c   = EXC_NONE;
        flush_c  = 1'b0;
        new_pc_c = 32'h0;
        if (slot_valid) begin
            if (int_pending) begin
                code_c = EXC_INT;
            end else if (syscall_i) begin
                code_c = EXC_SYSCALL;
            end else if (inst_invalid_i) begin
                code_c = EXC_INVALID;
            end else if (trap_i) begin
                code_c = EXC_TRAP;
            end else if (ov_i) begin
                code_c = EXC_OV;
            end else if (eret_i) begin
                code_c = EXC_ERET;
            end
        end
        flush_c = (code_c != EXC_NONE);
        if (flush_c) begin
            new_pc_c = (code_c == EXC_ERET) ? epc_f : EXC_VECTOR;
        end
    end

    assign excepttype_o        = code_c;
    assign flush_o             = flush_c;
    assign new_pc_o            = new_pc_c;
    assign quiet_o             = !rst && (state_q == S_QUIET);
    assign current_inst_addr_o = inst_addr_i;
    assign is_in_delayslot_o   = is_in_delayslot_i;

    // Quiet-window next-state: load on flush, count down, leave after zero
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        case (state_q)
            S_IDLE: begin
                if (flush_c) begin
                    state_d = S_QUIET;
                    qcnt_d  = QCNT_LOAD;
                end
            end
            S_QUIET: begin
                if (qcnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    qcnt_d = qcnt_q - QCNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                qcnt_d  = '0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
        end
    end

    // Register bits that play no part in exception decisions
    logic unused_bits;
    assign unused_bits = ^{status_f[31:16], status_f[7:2],
                           cause_f[31:16], cause_f[7:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed, table-driven bench for exc_ctrl.
module tb_exc_ctrl;

    localparam int unsigned LQ = 3;
    localparam int NV = 15;

    localparam logic [4:0] F_SYS = 5'b10000;
    localparam logic [4:0] F_INV = 5'b01000;
    localparam logic [4:0] F_TRP = 5'b00100;
    localparam logic [4:0] F_OV  = 5'b00010;
    localparam logic [4:0] F_ER  = 5'b00001;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_raw_i;
    logic [5:0]  int_o;
    logic        syscall_i, inst_invalid_i, trap_i, ov_i, eret_i;
    logic [31:0] inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] excepttype_o, current_inst_addr_o, new_pc_o;
    logic        is_in_delayslot_o, flush_o, quiet_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  flags;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] exp_code;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [NV];

    exc_ctrl #(.EXC_VECTOR(32'h0000_0020), .QUIET_CYCLES(LQ)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .int_raw_i           (int_raw_i),
        .int_o               (int_o),
        .syscall_i           (syscall_i),
        .inst_invalid_i      (inst_invalid_i),
        .trap_i              (trap_i),
        .ov_i                (ov_i),
        .eret_i              (eret_i),
        .inst_addr_i         (inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .cp0_status_i        (cp0_status_i),
        .cp0_cause_i         (cp0_cause_i),
        .cp0_epc_i           (cp0_epc_i),
        .wb_cp0_we_i         (wb_cp0_we_i),
        .wb_cp0_waddr_i      (wb_cp0_waddr_i),
        .wb_cp0_data_i       (wb_cp0_data_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .quiet_o             (quiet_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_addr_i       = 32'h0;
        {syscall_i, inst_invalid_i, trap_i, ov_i, eret_i} = 5'b0;
        is_in_delayslot_i = 1'b0;
        cp0_status_i      = 32'h0;
        cp0_cause_i       = 32'h0;
        cp0_epc_i         = 32'h0;
        wb_cp0_we_i       = 1'b0;
        wb_cp0_waddr_i    = 5'd0;
        wb_cp0_data_i     = 32'h0;
    endtask

    task automatic apply(input vec_t v);
        inst_addr_i    = v.addr;
        {syscall_i, inst_invalid_i, trap_i, ov_i, eret_i} = v.flags;
        cp0_status_i   = v.status;
        cp0_cause_i    = v.cause;
        cp0_epc_i      = v.epc;
        wb_cp0_we_i    = v.we;
        wb_cp0_waddr_i = v.waddr;
        wb_cp0_data_i  = v.wdata;
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [4:0] flags,
                                input logic [31:0] st, input logic [31:0] ca,
                                input logic [31:0] epc, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd,
                                input logic [31:0] code, input logic [31:0] pc);
        vec_t v;
        v.addr = addr; v.flags = flags; v.status = st; v.cause = ca; v.epc = epc;
        v.we = we; v.waddr = wa; v.wdata = wd; v.exp_code = code; v.exp_pc = pc;
        return v;
    endfunction

    // Wait out the quiet window, checking quiet_o each cycle
    task automatic drain(input logic exp_quiet, input string tag);
        idle();
        for (int k = 0; k < int'(LQ); k++) begin
            #1;
            chk($sformatf("%s_quiet%0d", tag, k), 32'(quiet_o), 32'(exp_quiet));
            cyc();
        end
    endtask

    initial begin
        //            addr          flags               status        cause         epc           we    wa     wdata         code   pc
        vecs[0]  = mk(32'h100, F_SYS,               32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h08, 32'h20);
        vecs[1]  = mk(32'h100, F_OV,                32'h0000_0401, 32'h0000_0400, 32'h0,     1'b0, 5'd0,  32'h0,        32'h01, 32'h20);
        vecs[2]  = mk(32'h100, F_OV,                32'h0000_0403, 32'h0000_0400, 32'h0,     1'b0, 5'd0,  32'h0,        32'h0c, 32'h20);
        vecs[3]  = mk(32'h100, F_ER,                32'h0,        32'h0,        32'h200,      1'b1, 5'd14, 32'h300,      32'h0e, 32'h300);
        vecs[4]  = mk(32'h100, 5'b0,                32'h0000_ff01, 32'h0,       32'h0,        1'b1, 5'd13, 32'hffff_ffff, 32'h01, 32'h20);
        vecs[5]  = mk(32'h100, 5'b0,                32'h0000_fc01, 32'h0,       32'h0,        1'b1, 5'd13, 32'hffff_ffff, 32'h00, 32'h0);
        vecs[6]  = mk(32'h0,   F_TRP,               32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h00, 32'h0);
        vecs[7]  = mk(32'h0,   5'b0,                32'h0000_0401, 32'h0000_0400, 32'h0,     1'b0, 5'd0,  32'h0,        32'h00, 32'h0);
        vecs[8]  = mk(32'h104, F_INV|F_TRP|F_OV|F_ER, 32'h0,      32'h0,        32'h200,      1'b0, 5'd0,  32'h0,        32'h0a, 32'h20);
        vecs[9]  = mk(32'h108, F_TRP|F_OV,          32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h0d, 32'h20);
        vecs[10] = mk(32'h10c, F_OV,                32'h0000_0401, 32'h0000_0400, 32'h0,     1'b1, 5'd12, 32'h0000_0403, 32'h0c, 32'h20);
        vecs[11] = mk(32'h110, 5'b0,                32'h0000_0400, 32'h0000_0400, 32'h0,     1'b0, 5'd0,  32'h0,        32'h00, 32'h0);
        vecs[12] = mk(32'h114, F_ER,                32'h0,        32'h0,        32'h200,      1'b0, 5'd14, 32'h300,      32'h0e, 32'h200);
        vecs[13] = mk(32'h118, 5'b0,                32'h0000_0401, 32'h0000_0400, 32'h0,     1'b1, 5'd13, 32'h0,        32'h01, 32'h20);
        vecs[14] = mk(32'h11c, F_SYS|F_INV,         32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h08, 32'h20);

        // Reset with interrupts high and a live syscall: everything forced quiet
        rst = 1'b1;
        int_raw_i = 6'h3f;
        idle();
        inst_addr_i = 32'h100;
        syscall_i   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk($sformatf("rst_int%0d", k),   32'(int_o),   32'h0);
            chk($sformatf("rst_flush%0d", k), 32'(flush_o), 32'h0);
            chk($sformatf("rst_quiet%0d", k), 32'(quiet_o), 32'h0);
            chk($sformatf("rst_code%0d", k),  excepttype_o, 32'h0);
            chk($sformatf("rst_pc%0d", k),    new_pc_o,     32'h0);
        end
        rst = 1'b0;
        idle();
        cyc();
        chk("sync_edge1", 32'(int_o), 32'h0);
        cyc();
        chk("sync_edge2", 32'(int_o), 32'h3f);
        int_raw_i = 6'h05;
        cyc();
        chk("sync_chg1", 32'(int_o), 32'h3f);
        cyc();
        chk("sync_chg2", 32'(int_o), 32'h05);

        // Table-driven single-cycle decode vectors
        for (int i = 0; i < NV; i++) begin
            logic exp_flush;
            exp_flush = (vecs[i].exp_code != 32'h0);
            apply(vecs[i]);
            is_in_delayslot_i = i[0];
            #1;
            chk($sformatf("v%0d_code", i),  excepttype_o, vecs[i].exp_code);
            chk($sformatf("v%0d_flush", i), 32'(flush_o), 32'(exp_flush));
            chk($sformatf("v%0d_quiet", i), 32'(quiet_o), 32'h0);
            chk($sformatf("v%0d_addr", i),  current_inst_addr_o, vecs[i].addr);
            chk($sformatf("v%0d_ds", i),    32'(is_in_delayslot_o), 32'(i[0]));
            if (exp_flush) begin
                chk($sformatf("v%0d_pc", i), new_pc_o, vecs[i].exp_pc);
            end
            cyc();
            drain(exp_flush, $sformatf("v%0d", i));
        end

        // Back-to-back: trap at N, syscall held through quiet, taken at N+4
        apply(mk(32'h200, F_TRP, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0));
        #1;
        chk("b2b_n_code",  excepttype_o, 32'h0d);
        chk("b2b_n_flush", 32'(flush_o), 32'h1);
        cyc();
        for (int k = 1; k <= int'(LQ); k++) begin
            apply(mk(32'h204, F_SYS, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0));
            #1;
            chk($sformatf("b2b_q%0d_flush", k), 32'(flush_o), 32'h0);
            chk($sformatf("b2b_q%0d_code", k),  excepttype_o, 32'h0);
            chk($sformatf("b2b_q%0d_quiet", k), 32'(quiet_o), 32'h1);
            cyc();
        end
        #1;
        chk("b2b_n4_flush", 32'(flush_o), 32'h1);
        chk("b2b_n4_code",  excepttype_o, 32'h08);
        chk("b2b_n4_quiet", 32'(quiet_o), 32'h0);
        chk("b2b_n4_pc",    new_pc_o, 32'h20);
        cyc();
        drain(1'b1, "b2b_tail");

        // Reset in the middle of the quiet window returns straight to IDLE
        apply(mk(32'h300, F_SYS, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0));
        #1;
        chk("rq_flush", 32'(flush_o), 32'h1);
        cyc();
        idle();
        #1;
        chk("rq_quiet", 32'(quiet_o), 32'h1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rq_after_rst_quiet", 32'(quiet_o), 32'h0);
        apply(mk(32'h304, F_SYS, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0));
        #1;
        chk("rq_accept_flush", 32'(flush_o), 32'h1);
        chk("rq_accept_code",  excepttype_o, 32'h08);
        cyc();
        drain(1'b1, "rq_tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
